// File: rtl/ptw_mem_arbiter_pkg.sv
// ptw_mem_arbiter_pkg: shared CSR constants, walker arbiter FSM encodings and requester IDs.
package ptw_mem_arbiter_pkg;
    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam int          SATP_MODE_BIT = 31;

    typedef enum logic [1:0] {IDLE, READ, CAPT, RESP} state_e;

    localparam logic REQ_IMEM = 1'b0;
    localparam logic REQ_DMEM = 1'b1;

    // Unsigned window check: below base, past the end, or not word aligned.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] limit);
        return addr < base || (addr - base) >= limit || addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/ptw_mem_arbiter_pick.sv
// ptw_arb_pick: chooses the walker to grant; on a tie the one not granted last wins.
module ptw_arb_pick
    import ptw_mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic grant_d,
    output logic valid
);
    always_comb begin
        valid   = req_i | req_d;
        grant_d = (req_i && req_d) ? ~last : (req_d ? REQ_DMEM : REQ_IMEM);
    end
endmodule

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one synchronous memory port between the IMEM and DMEM page-table walkers.
// Define PTW_ARB_RR_EN for round-robin tie breaking; otherwise IMEM always wins a tie.
module ptw_mem_arbiter
    import ptw_mem_arbiter_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = 32'h8000_0000,
    parameter int          MEMSIZE  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        resolved_i,
    output logic [31:0] word_i,
    output logic        err_i,
    input  logic        req_d,
    input  logic [31:0] addr_d,
    output logic        resolved_d,
    output logic [31:0] word_d,
    output logic        err_d,
    output logic        mem_rd_en,
    output logic [31:0] mem_index,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [31:0] LIMIT = 32'(MEMSIZE * 4);

    state_e      state_q, state_d;
    logic        win_q, win_d, bad_q, bad_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] word_i_q, word_i_d, word_d_q, word_d_d;
    logic        err_i_q, err_i_d, err_d_q, err_d_d;
    logic        last, pick, pick_v, grant, load;
    logic [31:0] req_addr;

    ptw_arb_pick u_pick (
        .req_i   (req_i),
        .req_d   (req_d),
        .last    (last),
        .grant_d (pick),
        .valid   (pick_v)
    );

`ifdef PTW_ARB_RR_EN
    logic last_q, last_d;
    assign last   = last_q;
    assign last_d = grant ? pick : last_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= REQ_DMEM;
        else     last_q <= last_d;
`else
    assign last = REQ_DMEM;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= REQ_IMEM;
            bad_q    <= 1'b0;
            idx_q    <= '0;
            word_i_q <= '0;
            word_d_q <= '0;
            err_i_q  <= 1'b0;
            err_d_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            bad_q    <= bad_d;
            idx_q    <= idx_d;
            word_i_q <= word_i_d;
            word_d_q <= word_d_d;
            err_i_q  <= err_i_d;
            err_d_q  <= err_d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_v) state_d = addr_bad(req_addr, RAM_BASE, LIMIT) ? CAPT : READ;
            READ:    state_d = CAPT;
            CAPT:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Grant-time latches; only the winner's word/err registers move in CAPT.
    always_comb begin
        req_addr = (pick == REQ_DMEM) ? addr_d : addr_i;
        grant    = state_q == IDLE && pick_v;
        load     = state_q == CAPT;
        win_d    = grant ? pick : win_q;
        bad_d    = grant ? addr_bad(req_addr, RAM_BASE, LIMIT) : bad_q;
        idx_d    = grant ? (req_addr - RAM_BASE) >> 2 : idx_q;
        word_i_d = (load && win_q == REQ_IMEM) ? (bad_q ? '0 : mem_rdata) : word_i_q;
        err_i_d  = (load && win_q == REQ_IMEM) ? bad_q : err_i_q;
        word_d_d = (load && win_q == REQ_DMEM) ? (bad_q ? '0 : mem_rdata) : word_d_q;
        err_d_d  = (load && win_q == REQ_DMEM) ? bad_q : err_d_q;
    end

    always_comb begin
        busy       = state_q != IDLE;
        mem_rd_en  = state_q == READ;
        mem_index  = mem_rd_en ? idx_q : '0;
        resolved_i = state_q == RESP && win_q == REQ_IMEM;
        resolved_d = state_q == RESP && win_q == REQ_DMEM;
        word_i     = word_i_q;
        word_d     = word_d_q;
        err_i      = err_i_q;
        err_d      = err_d_q;
    end
endmodule

// File: doc/ptw_mem_arbiter.md
PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_BASE, default 32'h8000_0000, physical base address of unified memory.
REQ-002 The block SHALL have parameter MEMSIZE, default 20000, unified memory depth in 32-bit words.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_i  input  1  IMEM walker page-table read request, level.
REQ-006 The block SHALL have port addr_i  input  32  IMEM walker physical PTE address.
REQ-007 The block SHALL have port resolved_i  output  1  IMEM response valid, one-cycle pulse.
REQ-008 The block SHALL have port word_i  output  32  IMEM returned PTE word, held until the next IMEM grant.
REQ-009 The block SHALL have port err_i  output  1  IMEM access fault, valid with resolved_i.
REQ-010 The block SHALL have ports req_d, addr_d, resolved_d, word_d and err_d, with identical widths and meanings for the DMEM walker.
REQ-011 The block SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-012 The block SHALL have port mem_index  output  32  word index (addr - RAM_BASE) >> 2.
REQ-013 The block SHALL have port mem_rdata  input  32  synchronous read data, valid one cycle after mem_rd_en.
REQ-014 The block SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, READ, CAPT and RESP.
REQ-016 In IDLE with any req asserted, the FSM SHALL latch the winner and its address, then go to READ, or to CAPT when the address is invalid.
REQ-017 An address SHALL be invalid when addr < RAM_BASE, or (addr - RAM_BASE) >= MEMSIZE*4, or addr[1:0] != 0; comparisons SHALL be unsigned 32-bit.
REQ-018 READ SHALL assert mem_rd_en for exactly one cycle with mem_index driven from the latched address, then go to CAPT.
REQ-019 CAPT SHALL load mem_rdata into the winner's word register with err cleared; on an invalid address it SHALL load 32'h0 with err set, and mem_rd_en SHALL never be asserted for that request.
REQ-020 RESP SHALL assert the winner's resolved output for one cycle, then return to IDLE.
REQ-021 Latency SHALL be: req sampled in IDLE at cycle N; resolved at N+3 when valid, N+2 when invalid.
REQ-022 Requests SHALL be ignored outside IDLE; a req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-023 Only the winner's word and err SHALL change; the loser's registers SHALL hold their values.
REQ-024 resolved_i and resolved_d SHALL never be high in the same cycle; mem_rd_en SHALL never be high outside READ.
REQ-025 A change to a requester's addr after grant SHALL NOT affect the grant in progress.

Reset
REQ-026 Asserting rst SHALL immediately force state IDLE and drive all outputs to 0, including word_i and word_d, mem_index and busy.
REQ-027 Asserting rst SHALL clear the round-robin pointer to "last = DMEM".
REQ-028 A reset mid-transaction SHALL drop the transaction and SHALL NOT issue its response after release.

Configuration
REQ-029 With PTW_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the pointer updates on each grant, so IMEM wins first after reset.
REQ-030 Without PTW_ARB_RR_EN, IMEM SHALL always win simultaneous requests and no pointer register SHALL exist.

Structure
REQ-031 The FSM state encodings and the requester IDs (IMEM=0, DMEM=1) SHALL live in the shared package alongside the existing csr_defs constants.
REQ-032 The winner selection SHALL be a sub-module ptw_arb_pick (req_i, req_d, last → grant_d, valid); this is the only sub-module.

Verification
REQ-033 The bench SHALL drive req_i alone with addr_i=32'h8000_0010 and mem_rdata=32'h2000_0C01 -> required response: mem_rd_en at N+1 with mem_index=4; resolved_i at N+3 with word_i=32'h2000_0C01 and err_i=0.
REQ-034 The bench SHALL drive req_d with addr_d=32'h7FFF_FFFC -> required response: no mem_rd_en; resolved_d at N+2 with err_d=1 and word_d=0.
REQ-035 The bench SHALL drive addr_d=RAM_BASE+MEMSIZE*4 and then addr_d=32'h8000_0002 -> required response: err_d=1 for both requests.
REQ-036 The bench SHALL hold req_i and req_d high for 4 transactions with PTW_ARB_RR_EN defined -> required grant order: I, D, I, D; without the macro -> I, I, I, I.
REQ-037 The bench SHALL assert rst during READ -> required response: all outputs 0 at once and no resolved pulse after release; the next req_i/req_d pair SHALL be granted to IMEM.
REQ-038 The bench SHALL give IMEM then DMEM consecutive grants -> required response: word_i holds its value across the DMEM transaction; no cycle with both resolved outputs high.
